// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - issue/writeback handshake bundle for alu_mc
// Master drives operands and out_ready; slave (the ALU) returns result and flags.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             ZF;
  logic             CF;
  logic             OF;
  logic             SF;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out, ZF, CF, OF, SF
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out, ZF, CF, OF, SF
  );
endinterface

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with registered result/flags and valid/ready handshakes
// Single-cycle ops complete at accept; MUL/DIVU/REMU iterate one bit per cycle.
module alu_mc #(
  parameter int WIDTH  = 32,
  parameter bit MDU_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_mc_if.slave   io
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_INC  = 4'b1010;
  localparam logic [3:0] OP_DEC  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_DIVU = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] out_q;
  logic             zf_q, cf_q, of_q, sf_q;
  logic [3:0]       op_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] acc_q, a_q, b_q;
  logic [WIDTH-1:0] acc_d, a_d, b_d;

  logic             in_ready_w;
  logic             accept;
  logic             is_mdu;

  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   add_ext, sub_ext;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cf, alu_of;

  logic [WIDTH:0]   rem_shift, rem_diff;
  logic [WIDTH-1:0] mdu_res;
  logic             mdu_of;

  assign in_ready_w   = (state_q == IDLE) || (state_q == DONE && io.out_ready);
  assign accept       = io.in_valid && in_ready_w;
  assign is_mdu       = MDU_EN && (io.op == OP_MUL || io.op == OP_DIVU || io.op == OP_REMU);

  assign io.in_ready  = in_ready_w;
  assign io.out_valid = (state_q == DONE);
  assign io.out       = out_q;
  assign io.ZF        = zf_q;
  assign io.CF        = cf_q;
  assign io.OF        = of_q;
  assign io.SF        = sf_q;

  // Single-cycle datapath works on the live inputs; its result is captured at accept.
  always_comb begin
    opnd    = (io.op == OP_INC || io.op == OP_DEC) ? WIDTH'(1) : io.b;
    add_ext = {1'b0, io.a} + {1'b0, opnd};
    sub_ext = {1'b0, io.a} - {1'b0, opnd};
    sh      = io.b[SHW-1:0];
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    case (io.op)
      OP_ADD, OP_INC: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_cf  = add_ext[WIDTH];
        alu_of  = (io.a[WIDTH-1] == opnd[WIDTH-1]) && (add_ext[WIDTH-1] != io.a[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_cf  = sub_ext[WIDTH];
        alu_of  = (io.a[WIDTH-1] != opnd[WIDTH-1]) && (sub_ext[WIDTH-1] != io.a[WIDTH-1]);
      end
      OP_SLL:  alu_res = io.a << sh;
      OP_SRL:  alu_res = io.a >> sh;
      OP_SRA:  alu_res = WIDTH'($signed(io.a) >>> sh);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(io.a) < $signed(io.b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, io.a < io.b};
      OP_XOR:  alu_res = io.a ^ io.b;
      OP_OR:   alu_res = io.a | io.b;
      OP_AND:  alu_res = io.a & io.b;
      default: alu_res = '0;
    endcase
  end

  // One iteration step. MUL: acc += a_q when b_q[0], a_q shifts up, b_q down.
  // DIVU/REMU: acc is the partial remainder, a_q shifts the dividend out and the quotient in.
  // With b_q==0 every trial subtract succeeds, giving all-ones quotient and remainder==a.
  always_comb begin
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_shift = {acc_q, a_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
    if (op_q == OP_MUL) begin
      acc_d = b_q[0] ? acc_q + a_q : acc_q;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
    end else if (!rem_diff[WIDTH]) begin
      acc_d = rem_diff[WIDTH-1:0];
      a_d   = {a_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = rem_shift[WIDTH-1:0];
      a_d   = {a_q[WIDTH-2:0], 1'b0};
    end
    mdu_res = (op_q == OP_DIVU) ? a_d : acc_d;
    mdu_of  = (op_q != OP_MUL) && (b_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      of_q    <= 1'b0;
      sf_q    <= 1'b0;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (is_mdu) begin
              state_q <= BUSY;
              op_q    <= io.op;
              cnt_q   <= SHW'(WIDTH - 1);
              acc_q   <= '0;
              a_q     <= io.a;
              b_q     <= io.b;
            end else begin
              state_q <= DONE;
              out_q   <= alu_res;
              zf_q    <= (alu_res == '0);
              cf_q    <= alu_cf;
              of_q    <= alu_of;
              sf_q    <= alu_res[WIDTH-1];
            end
          end else if (state_q == DONE && io.out_ready) begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          a_q   <= a_d;
          b_q   <= b_d;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == '0) begin
            state_q <= DONE;
            out_q   <= mdu_res;
            zf_q    <= (mdu_res == '0);
            cf_q    <= 1'b0;
            of_q    <= mdu_of;
            sf_q    <= mdu_res[WIDTH-1];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
